// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the N-way instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_ADDR,
    REFILL,
    RESP,
    UNC_ADDR,
    UNC_READ
  } state_t;

  localparam int ARLEN_W = 8;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid flops, tag array and word-addressed data array.
module icache_way #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 21,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = $clog2(SETS),
  parameter int WOFF_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WOFF_W-1:0] rd_woff,
  input  logic [TAG_W-1:0]  cmp_tag,
  output logic              hit,
  output logic              valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_woff,
  input  logic              word_we,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [SETS-1:0]   valid_reg;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_reg <= '0;
    end else if (tag_we) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_idx] <= wr_tag;
    end
    if (word_we) begin
      data_mem[{wr_idx, wr_woff}] <= wr_data;
    end
  end

  assign valid   = valid_reg[rd_idx];
  assign hit     = valid && (tag_mem[rd_idx] == cmp_tag);
  assign rd_data = data_mem[{rd_idx, rd_woff}];

endmodule

// File: rtl/inst_cache_nway.sv
// N-way set-associative instruction cache with round-robin replacement and uncached bypass.
module inst_cache_nway
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cache_ena,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [DATA_W-1:0]  s_rdata,
  output logic               s_rvalid,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic [ARLEN_W-1:0] m_arlen,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               m_rvalid,
  input  logic               m_rlast,
  output logic               m_rready
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WOFF_W = OFF_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]  req_addr_reg;
  logic [WAY_W-1:0]   victim_reg;
  logic [WAY_W-1:0]   rr_reg [SETS];
  logic [WOFF_W-1:0]  beat_reg;
  logic               flush_pend_reg;
  logic [DATA_W-1:0]  s_rdata_reg;
  logic               s_rvalid_reg;
  logic [ADDR_W-1:0]  m_araddr_reg;
  logic [ARLEN_W-1:0] m_arlen_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic [WAYS-1:0]   way_hit, way_valid, way_word_we, way_tag_we;
  logic [DATA_W-1:0] way_rdata [WAYS];
  logic [DATA_W-1:0] hit_data;
  logic [WAY_W-1:0]  victim_sel;
  logic              any_hit, accept, beat_fire, last_beat, drop_line, install;
  logic              unused_rlast;

  // The beat counter, not m_rlast, decides when a refill is complete.
  assign unused_rlast = m_rlast;

  assign req_tag   = req_addr_reg[ADDR_W-1:OFF_W+IDX_W];
  assign req_idx   = req_addr_reg[OFF_W+IDX_W-1:OFF_W];
  assign req_woff  = req_addr_reg[OFF_W-1:2];
  assign any_hit   = |way_hit;
  assign accept    = s_arvalid && s_arready;
  assign beat_fire = (state_reg == REFILL) && m_rvalid;
  assign last_beat = (beat_reg == WOFF_W'(LINE_WORDS - 1));
  assign drop_line = flush || flush_pend_reg;
  assign install   = beat_fire && last_beat && !drop_line;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_word_we[gi] = beat_fire && (victim_reg == WAY_W'(gi));
      assign way_tag_we[gi]  = install && (victim_reg == WAY_W'(gi));

      icache_way #(
        .SETS      (SETS),
        .LINE_WORDS(LINE_WORDS),
        .TAG_W     (TAG_W),
        .DATA_W    (DATA_W)
      ) u_way (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .rd_idx (req_idx),
        .rd_woff(req_woff),
        .cmp_tag(req_tag),
        .hit    (way_hit[gi]),
        .valid  (way_valid[gi]),
        .rd_data(way_rdata[gi]),
        .wr_idx (req_idx),
        .wr_woff(beat_reg),
        .word_we(way_word_we[gi]),
        .wr_data(m_rdata),
        .tag_we (way_tag_we[gi]),
        .wr_tag (req_tag)
      );
    end
  endgenerate

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_hit[i]) hit_data = hit_data | way_rdata[i];
    end
  end

  // Descending scan so the lowest-index invalid way wins over the pointer.
  always_comb begin
    victim_sel = rr_reg[req_idx];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim_sel = WAY_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    s_arready  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    case (state_reg)
      IDLE: begin
        s_arready = !flush && !rst;
        if (s_arvalid && !flush && !rst) state_next = cache_ena ? LOOKUP : UNC_ADDR;
      end
      LOOKUP: begin
        if (flush || any_hit) state_next = IDLE;
        else                  state_next = MISS_ADDR;
      end
      MISS_ADDR: begin
        m_arvalid = !rst;
        if (m_arready) state_next = REFILL;
      end
      REFILL: begin
        m_rready = !rst;
        if (m_rvalid && last_beat) state_next = drop_line ? IDLE : RESP;
      end
      RESP: state_next = IDLE;
      UNC_ADDR: begin
        m_arvalid = !rst;
        if (m_arready) state_next = UNC_READ;
      end
      UNC_READ: begin
        m_rready = !rst;
        if (m_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_reg   <= '0;
      victim_reg     <= '0;
      beat_reg       <= '0;
      flush_pend_reg <= 1'b0;
      s_rdata_reg    <= '0;
      s_rvalid_reg   <= 1'b0;
      m_araddr_reg   <= '0;
      m_arlen_reg    <= '0;
      for (int i = 0; i < SETS; i++) rr_reg[i] <= '0;
    end else begin
      s_rvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_addr_reg <= s_araddr;
            if (!cache_ena) begin
              m_araddr_reg <= s_araddr;
              m_arlen_reg  <= '0;
            end
          end
        end
        LOOKUP: begin
          if (!flush) begin
            if (any_hit) begin
              s_rdata_reg  <= hit_data;
              s_rvalid_reg <= 1'b1;
            end else begin
              victim_reg     <= victim_sel;
              beat_reg       <= '0;
              flush_pend_reg <= 1'b0;
              m_araddr_reg   <= {req_addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              m_arlen_reg    <= ARLEN_W'(LINE_WORDS - 1);
            end
          end
        end
        MISS_ADDR: begin
          if (flush) flush_pend_reg <= 1'b1;
        end
        REFILL: begin
          if (flush) flush_pend_reg <= 1'b1;
          if (m_rvalid) begin
            beat_reg <= beat_reg + 1'b1;
            if (beat_reg == req_woff) s_rdata_reg <= m_rdata;
            if (last_beat) begin
              flush_pend_reg <= 1'b0;
              if (!drop_line) begin
                s_rvalid_reg    <= 1'b1;
                rr_reg[req_idx] <= (rr_reg[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                   : rr_reg[req_idx] + 1'b1;
              end
            end
          end
        end
        UNC_READ: begin
          if (m_rvalid) begin
            s_rdata_reg  <= m_rdata;
            s_rvalid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_rdata  = s_rdata_reg;
  assign s_rvalid = s_rvalid_reg;
  assign m_araddr = m_araddr_reg;
  assign m_arlen  = m_arlen_reg;

endmodule

// File: tb/tb_inst_cache_nway.sv
// Bench for inst_cache_nway: directed vector table, mid-refill flush sequence, random traffic vs model.
module tb_inst_cache_nway;
  localparam int WAYS = 2;
  localparam int SETS = 64;
  localparam int LW   = 8;
  localparam logic [31:0] SALT6 = 32'h12345678 ^ 32'hFEDCBA92;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cache_ena = 1'b1;
  logic flush_main = 1'b0;
  logic flush_sl = 1'b0;
  logic flush;
  logic [31:0] s_araddr = '0;
  logic s_arvalid = 1'b0;
  logic s_arready;
  logic [31:0] s_rdata;
  logic s_rvalid;
  logic [31:0] m_araddr;
  logic [7:0] m_arlen;
  logic m_arvalid;
  logic m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic m_rvalid = 1'b0;
  logic m_rlast = 1'b0;
  logic m_rready;

  assign flush = flush_main | flush_sl;

  inst_cache_nway #(.ADDR_W(32), .DATA_W(32), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .cache_ena(cache_ena), .flush(flush),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_salt = '0;
  int flush_at_beat = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'hFEDCBA90 + (a >> 2)) ^ mem_salt;
  endfunction

  // AXI slave: decides handshakes at the negedge ahead of the edge they take effect on.
  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;
  burst_t burst_q[$];
  int beats_total = 0;
  int last_beat_cyc = 0;
  int ar_unstable = 0;

  initial begin
    int sl_left;
    int sl_idx;
    logic [31:0] sl_addr;
    bit ar_wait;
    logic [31:0] prev_addr;
    logic [7:0] prev_len;
    sl_left = 0; sl_idx = 0; sl_addr = '0; ar_wait = 0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast = 1'b0;
      flush_sl = 1'b0;
      m_arready = 1'b0;
      if (rst) begin
        sl_left = 0;
        ar_wait = 0;
      end else begin
        if (sl_left > 0 && m_rready && $urandom_range(0, 3) != 0) begin
          m_rvalid = 1'b1;
          m_rdata = mem_word(sl_addr + 32'(4 * sl_idx));
          m_rlast = (sl_left == 1);
          if (sl_idx == flush_at_beat) flush_sl = 1'b1;
          sl_idx++;
          sl_left--;
          beats_total++;
          if (sl_left == 0) last_beat_cyc = cyc;
        end
        if (m_arvalid && sl_left == 0) begin
          if (ar_wait && (m_araddr != prev_addr || m_arlen != prev_len)) ar_unstable++;
          if ($urandom_range(0, 2) != 0) begin
            m_arready = 1'b1;
            burst_q.push_back('{m_araddr, m_arlen});
            sl_addr = m_araddr;
            sl_left = int'(m_arlen) + 1;
            sl_idx = 0;
            ar_wait = 0;
          end else begin
            ar_wait = 1;
            prev_addr = m_araddr;
            prev_len = m_arlen;
          end
        end else begin
          ar_wait = 0;
        end
      end
    end
  end

  // Reference model: plain set-associative bookkeeping over whole lines.
  bit          mdl_valid [WAYS][SETS];
  logic [31:0] mdl_tag   [WAYS][SETS];
  logic [31:0] mdl_data  [WAYS][SETS][LW];
  int          mdl_rr    [SETS];

  task automatic model_flush();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) mdl_valid[w][s] = 0;
  endtask

  task automatic model_access(input logic [31:0] addr, input bit ena,
                              output logic [31:0] data, output bit burst,
                              output logic [31:0] baddr, output logic [7:0] blen);
    int idx, woff, victim;
    logic [31:0] tag, line;
    bit hit;
    if (!ena) begin
      data = mem_word(addr); burst = 1; baddr = addr; blen = 8'd0;
    end else begin
      idx = int'((addr / (LW * 4)) % SETS);
      tag = addr / (LW * 4 * SETS);
      woff = int'((addr / 4) % LW);
      line = addr - (addr % (LW * 4));
      hit = 0; data = '0; burst = 0; baddr = '0; blen = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (mdl_valid[w][idx] && mdl_tag[w][idx] == tag) begin
          hit = 1;
          data = mdl_data[w][idx][woff];
        end
      end
      if (!hit) begin
        victim = -1;
        for (int w = 0; w < WAYS; w++) if (!mdl_valid[w][idx] && victim < 0) victim = w;
        if (victim < 0) victim = mdl_rr[idx];
        for (int k = 0; k < LW; k++) mdl_data[victim][idx][k] = mem_word(line + 32'(4 * k));
        mdl_valid[victim][idx] = 1;
        mdl_tag[victim][idx] = tag;
        mdl_rr[idx] = (mdl_rr[idx] + 1) % WAYS;
        data = mdl_data[victim][idx][woff];
        burst = 1; baddr = line; blen = 8'(LW - 1);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush_main = 1'b1;
    @(negedge clk); flush_main = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input bit ena,
                         output logic [31:0] data, output bit got, output int lat,
                         output int nb, output logic [31:0] baddr, output logic [7:0] blen,
                         output int gap);
    int n0, c_acc, t;
    n0 = burst_q.size();
    @(negedge clk);
    s_araddr = addr; cache_ena = ena; s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 50) begin @(negedge clk); t++; end
    c_acc = cyc;
    @(negedge clk);
    s_arvalid = 1'b0;
    got = 0; t = 0;
    while (t < 300) begin
      if (s_rvalid) begin got = 1; break; end
      @(negedge clk); t++;
    end
    lat = cyc - c_acc;
    gap = cyc - last_beat_cyc;
    data = s_rdata;
    nb = burst_q.size() - n0;
    baddr = '0; blen = '0;
    if (nb > 0) begin baddr = burst_q[$].addr; blen = burst_q[$].len; end
  endtask

  task automatic txn(input string nm, input logic [31:0] addr, input bit ena, input bit fl,
                     input bit use_exp, input logic [31:0] e_data, input bit e_burst,
                     input logic [31:0] e_addr, input logic [7:0] e_len);
    logic [31:0] m_data, m_baddr, data, baddr;
    logic [7:0] m_blen, blen;
    bit m_burst, got;
    int lat, nb, gap;
    if (fl) begin pulse_flush(); model_flush(); end
    model_access(addr, ena, m_data, m_burst, m_baddr, m_blen);
    if (!use_exp) begin e_data = m_data; e_burst = m_burst; e_addr = m_baddr; e_len = m_blen; end
    do_read(addr, ena, data, got, lat, nb, baddr, blen, gap);
    chk({nm, "_rvalid"}, 32'(got), 32'd1);
    chk({nm, "_rdata"}, data, e_data);
    chk({nm, "_bursts"}, 32'(nb), 32'(e_burst));
    if (e_burst) begin
      chk({nm, "_araddr"}, baddr, e_addr);
      chk({nm, "_arlen"}, 32'(blen), 32'(e_len));
      chk({nm, "_resp_after_last_beat"}, 32'(gap), 32'd1);
    end else begin
      chk({nm, "_hit_latency"}, 32'(lat), 32'd2);
    end
    $display("txn %s addr=%h ena=%0d flush=%0d rdata=%h bursts=%0d araddr=%h arlen=%0d lat=%0d",
             nm, addr, ena, fl, data, nb, baddr, blen, lat);
  endtask

  typedef struct {
    string nm; logic [31:0] addr; bit ena; bit fl; logic [31:0] salt;
    logic [31:0] exp_data; bit exp_burst; logic [31:0] exp_araddr; logic [7:0] exp_len;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #600000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] data, baddr, addr;
    logic [7:0] blen;
    bit got, ena, fl;
    int lat, nb, gap, b0;

    vecs.push_back('{"cold0", 32'h00, 1, 0, 32'h0, 32'hFEDCBA90, 1, 32'h00, 8'd7});
    for (int i = 1; i < 8; i++)
      vecs.push_back('{"hitline", 32'(4 * i), 1, 0, 32'h0, 32'hFEDCBA90 + 32'(i), 0, 32'h0, 8'd0});
    vecs.push_back('{"cold1c", 32'h1C, 1, 1, 32'h0, 32'hFEDCBA97, 1, 32'h00, 8'd7});
    vecs.push_back('{"conf0000", 32'h0000, 1, 1, 32'h0, 32'hFEDCBA90, 1, 32'h0000, 8'd7});
    vecs.push_back('{"conf0800", 32'h0800, 1, 0, 32'h0, 32'hFEDCBC90, 1, 32'h0800, 8'd7});
    vecs.push_back('{"conf1000", 32'h1000, 1, 0, 32'h0, 32'hFEDCBE90, 1, 32'h1000, 8'd7});
    vecs.push_back('{"hit0800", 32'h0800, 1, 0, 32'h0, 32'hFEDCBC90, 0, 32'h0, 8'd0});
    vecs.push_back('{"evicted0000", 32'h0000, 1, 0, 32'h0, 32'hFEDCBA90, 1, 32'h0000, 8'd7});
    vecs.push_back('{"flushed04", 32'h04, 1, 1, 32'h0, 32'hFEDCBA91, 1, 32'h00, 8'd7});
    vecs.push_back('{"unc08", 32'h08, 0, 1, SALT6, 32'h12345678, 1, 32'h08, 8'd0});
    vecs.push_back('{"cached08", 32'h08, 1, 0, SALT6, 32'h12345678, 1, 32'h00, 8'd7});
    vecs.push_back('{"unc08res", 32'h08, 0, 0, SALT6, 32'h12345678, 1, 32'h08, 8'd0});
    vecs.push_back('{"hit0c", 32'h0C, 1, 0, SALT6, 32'h12345679, 0, 32'h0, 8'd0});

    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin mdl_valid[w][s] = 0; mdl_tag[w][s] = '0; end
    for (int s = 0; s < SETS; s++) mdl_rr[s] = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_arready", 32'(s_arready), 32'd0);
    chk("rst_s_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_rready", 32'(m_rready), 32'd0);
    chk("rst_s_rdata", s_rdata, 32'd0);
    chk("rst_m_araddr", m_araddr, 32'd0);
    chk("rst_m_arlen", 32'(m_arlen), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_arready", 32'(s_arready), 32'd1);

    foreach (vecs[i]) begin
      mem_salt = vecs[i].salt;
      txn(vecs[i].nm, vecs[i].addr, vecs[i].ena, vecs[i].fl, 1'b1, vecs[i].exp_data,
          vecs[i].exp_burst, vecs[i].exp_araddr, vecs[i].exp_len);
    end

    // Flush raised alongside refill beat 3: burst drains, nothing installed, no response.
    mem_salt = '0;
    pulse_flush();
    model_flush();
    flush_at_beat = 3;
    b0 = beats_total;
    do_read(32'h00, 1'b1, data, got, lat, nb, baddr, blen, gap);
    flush_at_beat = -1;
    model_flush();
    chk("midflush_no_rvalid", 32'(got), 32'd0);
    chk("midflush_beats", 32'(beats_total - b0), 32'd8);
    chk("midflush_bursts", 32'(nb), 32'd1);
    $display("txn midflush addr=00000000 rvalid=%0d beats=%0d", got, beats_total - b0);
    txn("midflush_reread", 32'h00, 1'b1, 1'b0, 1'b1, 32'hFEDCBA90, 1'b1, 32'h00, 8'd7);

    for (int n = 0; n < 150; n++) begin
      addr = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 5)
             | (32'($urandom_range(0, 7)) << 2);
      ena = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) mem_salt = $urandom;
      txn("rnd", addr, ena, fl, 1'b0, '0, 1'b0, '0, '0);
    end

    chk("ar_stable_while_waiting", 32'(ar_unstable), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_cache_nway.md
Name: inst_cache_nway

Overview:
Parametrised N-way set-associative instruction cache. It is the successor to the single-configuration inst_cache_fifo, sitting between the CPU fetch stage (s_* side) and the AXI read master (m_* side).
- New relative to inst_cache_fifo: configurable ways, sets and line length; per-set round-robin replacement; burst-length output; uncached single-beat bypass; defined flush-during-refill semantics.
- Read-only; no write-back path.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, word width; fixed 32 in this generation.
WAYS, 2, associativity; power of 2, 1..8.
SETS, 64, sets per way; power of 2, 2..256.
LINE_WORDS, 8, words per line and refill burst length; power of 2, 2..16.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
cache_ena  in  1  1 = cached access, 0 = uncached bypass; sampled at request acceptance.
flush  in  1  one-cycle pulse; invalidates all lines.
s_araddr  in  ADDR_W  fetch address, word aligned.
s_arvalid  in  1  fetch request valid.
s_arready  out  1  request accepted when s_arvalid && s_arready.
s_rdata  out  DATA_W  fetched instruction.
s_rvalid  out  1  one-cycle pulse; s_rdata valid. There is no s_rready.
m_araddr  out  ADDR_W  burst start address.
m_arlen  out  8  beats minus 1.
m_arvalid  out  1  read address valid; held until m_arready.
m_arready  in  1  read address accepted.
m_rdata  in  DATA_W  read beat data.
m_rvalid  in  1  beat valid.
m_rlast  in  1  last beat marker; informational only.
m_rready  out  1  beat accept.

Behaviour:
- Address split:
  - offset = addr[OFF_W-1:0], with OFF_W = log2(LINE_WORDS) + 2.
  - index = next log2(SETS) bits.
  - tag = the remaining upper bits.
- Storage: valid bits in flops; tag and data arrays are combinational-read, written at the clock edge.
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - All valid bits cleared; all round-robin pointers set to 0.
  - Outputs s_arready, s_rvalid, m_arvalid and m_rready are 0; s_rdata, m_araddr and m_arlen are 0.
  - Reset mid-refill abandons the burst; the AXI slave is in the same reset domain.
- States:
  - IDLE: s_arready = !flush. On accept, register the address and cache_ena, then go to LOOKUP if cached or UNC_ADDR if uncached.
  - LOOKUP: compare tags across all ways.
    - Hit: register s_rdata and pulse s_rvalid in the next cycle; return to IDLE.
    - Miss: select the victim and go to MISS_ADDR.
    - Hit latency: accept in cycle N, s_rvalid in cycle N+2.
  - MISS_ADDR: m_arvalid = 1, m_araddr = line-aligned address, m_arlen = LINE_WORDS-1. On m_arready, go to REFILL.
  - REFILL: m_rready = 1. Each m_rvalid beat is written into the victim line at word counter k (0..LINE_WORDS-1).
    - The counter is authoritative; m_rlast is not used for control.
    - On beat LINE_WORDS-1: write tag and valid, advance the set's round-robin pointer, go to RESP.
  - RESP: s_rvalid = 1 with the requested word (the line's word at the request offset); return to IDLE.
  - UNC_ADDR: m_araddr = exact address, m_arlen = 0, m_arvalid held until m_arready. Then go to UNC_READ.
  - UNC_READ: m_rready = 1. The first beat is forwarded: s_rvalid in the next cycle, no array update, then IDLE. The cache is not looked up even if the line is resident.
- Victim selection: the lowest-index invalid way; if all ways are valid, the set's round-robin pointer (log2(WAYS) bits, wraps WAYS-1 -> 0).
- Flush:
  - All valid bits clear at the edge where flush=1.
  - flush in LOOKUP: result discarded, no s_rvalid, go to IDLE.
  - flush in MISS_ADDR or REFILL: the burst is drained to completion, the line is NOT installed, no s_rvalid, then IDLE.
  - flush in RESP: the response is still delivered.
  - flush in UNC_*: no effect on the bypass response.
- Simultaneous flush and s_arvalid in IDLE: the request is not accepted (s_arready=0).
- m_arvalid, m_araddr and m_arlen stay stable while m_arvalid=1 and m_arready=0.

Decomposition:
- Package icache_pkg holds:
  - state enum (IDLE, LOOKUP, MISS_ADDR, REFILL, RESP, UNC_ADDR, UNC_READ);
  - field-width functions (OFF_W, IDX_W, TAG_W from the parameters);
  - the m_arlen width constant.
- Sub-module icache_way, instantiated WAYS times: valid flops, tag array and data array for one way; write enable per word and per tag; hit output.

Test Plan:
1. Defaults, cold read 0x00 with the RAM model returning 0xFEDCBA90..97 -> m_araddr=0x00, m_arlen=7, s_rdata=0xFEDCBA90. Then reads of 0x04..0x1C hit with s_rdata 0xFEDCBA91..97, each at accept+2, m_arvalid never set.
2. Cold read 0x1C -> m_araddr=0x00, 8 beats, s_rdata=0xFEDCBA97 in the cycle after the 8th beat.
3. Conflict, WAYS=2: fill 0x0000, 0x0800 and 0x1000 (all index 0) -> the third fill evicts way 0. A re-read of 0x0000 misses; 0x0800 hits.
4. After filling 0x00, pulse flush, then read 0x04 -> miss, new burst at 0x00.
5. flush asserted at refill beat 3 of read 0x00 -> remaining 4 beats accepted, no s_rvalid; the next read of 0x00 misses.
6. cache_ena=0, read 0x08, RAM returns 0x12345678 -> m_araddr=0x08, m_arlen=0, s_rdata=0x12345678. A following cached read of 0x08 misses, and m_arlen=7.
